// File: rtl/muxn_reg_nrisc_pkg.sv
// Shared nRISC definitions: select modes, output-buffer occupancy states and
// the channel-index width helper used by the operand multiplexer.
package nrisc_pkg;

  localparam int MODO_FIXO = 0;
  localparam int MODO_RR   = 1;

  // Occupancy of the output buffer: nothing, output register only, output + skid.
  typedef enum logic [1:0] {
    BUF_VAZIO = 2'd0,
    BUF_UM    = 2'd1,
    BUF_DOIS  = 2'd2
  } buf_estado_t;

  function automatic int idx_largura(input int canais);
    return (canais <= 2) ? 1 : $clog2(canais);
  endfunction

endpackage

// File: rtl/muxn_reg_nrisc_if.sv
// Channel-side and consumer-side bus of the registered N-way operand mux,
// plus read-only debug visibility of the buffer state and round-robin pointer.
interface muxn_reg_nrisc_if #(
  parameter int LARGURA = 8,
  parameter int CANAIS  = 4,
  parameter int IDX     = 2
) ();

  // Handshake: a word moves on a rising edge when valid and ready are both high
  // at that edge. Valid never waits for ready; the mux keeps saida/saida_canal
  // steady while saida_valido is high and saida_pronto is low.
  logic [CANAIS*LARGURA-1:0] entr;
  logic [CANAIS-1:0]         entr_valido;
  logic [CANAIS-1:0]         entr_pronto;
  logic [IDX-1:0]            sinal;
  logic [LARGURA-1:0]        saida;
  logic [IDX-1:0]            saida_canal;
  logic                      saida_valido;
  logic                      saida_pronto;
  nrisc_pkg::buf_estado_t    estado_dbg;
  logic [IDX-1:0]            ptr_dbg;

  modport master (
    output entr,
    output entr_valido,
    output sinal,
    output saida_pronto,
    input  entr_pronto,
    input  saida,
    input  saida_canal,
    input  saida_valido,
    input  estado_dbg,
    input  ptr_dbg
  );

  modport slave (
    input  entr,
    input  entr_valido,
    input  sinal,
    input  saida_pronto,
    output entr_pronto,
    output saida,
    output saida_canal,
    output saida_valido,
    output estado_dbg,
    output ptr_dbg
  );

endinterface

// File: rtl/muxn_reg_nrisc_arbitro.sv
// Round-robin priority search: first valid channel at or above ptr, wrapping
// around; tem_g is low when no channel is requesting.
module arbitro_rr_nrisc #(
  parameter int CANAIS = 4,
  parameter int IDX    = 2
) (
  input  logic [CANAIS-1:0] entr_valido,
  input  logic [IDX-1:0]    ptr,
  output logic [IDX-1:0]    g,
  output logic              tem_g
);

  logic [IDX-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    g     = '0;
    tem_g = 1'b0;
    cand  = '0;
    for (int k = CANAIS - 1; k >= 0; k--) begin
      cand = IDX'((int'(ptr) + k) % CANAIS);
      if (entr_valido[cand]) begin
        g     = cand;
        tem_g = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_reg_nrisc.sv
// Registered N-way operand multiplexer: explicit or round-robin channel grant
// feeding a 2-entry (output + skid) valid/ready buffer.
module muxn_reg_nrisc
  import nrisc_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CANAIS  = 4,
  parameter int MODO    = MODO_FIXO
) (
  input logic             clk,
  input logic             rst_n,
  muxn_reg_nrisc_if.slave bus
);

  localparam int IDX = idx_largura(CANAIS);

  buf_estado_t        estado_q, estado_d;
  logic [LARGURA-1:0] saida_q, saida_d;
  logic [LARGURA-1:0] skid_q, skid_d;
  logic [IDX-1:0]     canal_q, canal_d;
  logic [IDX-1:0]     skid_canal_q, skid_canal_d;
  logic [IDX-1:0]     ptr_q, ptr_d;

  logic [IDX-1:0]     g;
  logic               tem_g;
  logic [LARGURA-1:0] canal_dado [CANAIS];
  logic [LARGURA-1:0] palavra;
  logic               cheio;
  logic               skid_cheio;
  logic               entr_xfer;
  logic               saida_xfer;

  assign cheio      = (estado_q != BUF_VAZIO);
  assign skid_cheio = (estado_q == BUF_DOIS);

  always_comb begin
    for (int i = 0; i < CANAIS; i++) begin
      canal_dado[i] = bus.entr[i*LARGURA +: LARGURA];
    end
  end

  generate
    if (MODO == MODO_RR) begin : g_rr
      logic [IDX-1:0] g_arb;
      logic           tem_arb;

      arbitro_rr_nrisc #(
        .CANAIS (CANAIS),
        .IDX    (IDX)
      ) u_arbitro (
        .entr_valido (bus.entr_valido),
        .ptr         (ptr_q),
        .g           (g_arb),
        .tem_g       (tem_arb)
      );

      assign g     = g_arb;
      assign tem_g = tem_arb;
    end else begin : g_fixo
      // Out-of-range selects fall back to channel 0 rather than an empty grant.
      assign g     = (int'(bus.sinal) < CANAIS) ? bus.sinal : '0;
      assign tem_g = 1'b1;
    end
  endgenerate

  assign palavra = canal_dado[g];

  // Ready is granted even without a matching valid, so a stage can see where
  // the mux is pointing before it has data.
  always_comb begin
    bus.entr_pronto = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (tem_g && !skid_cheio && (g == IDX'(i))) begin
        bus.entr_pronto[i] = 1'b1;
      end
    end
  end

  assign entr_xfer  = tem_g && !skid_cheio && bus.entr_valido[g];
  assign saida_xfer = cheio && bus.saida_pronto;

  always_comb begin
    estado_d     = estado_q;
    saida_d      = saida_q;
    canal_d      = canal_q;
    skid_d       = skid_q;
    skid_canal_d = skid_canal_q;
    ptr_d        = ptr_q;

    case (estado_q)
      BUF_VAZIO: begin
        if (entr_xfer) begin
          saida_d  = palavra;
          canal_d  = g;
          estado_d = BUF_UM;
        end
      end
      BUF_UM: begin
        if (entr_xfer && saida_xfer) begin
          saida_d = palavra;
          canal_d = g;
        end else if (entr_xfer) begin
          skid_d       = palavra;
          skid_canal_d = g;
          estado_d     = BUF_DOIS;
        end else if (saida_xfer) begin
          estado_d = BUF_VAZIO;
        end
      end
      BUF_DOIS: begin
        if (saida_xfer) begin
          saida_d  = skid_q;
          canal_d  = skid_canal_q;
          estado_d = BUF_UM;
        end
      end
      default: begin
        estado_d = BUF_VAZIO;
      end
    endcase

    if ((MODO == MODO_RR) && entr_xfer) begin
      ptr_d = (g == IDX'(CANAIS - 1)) ? '0 : g + IDX'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q     <= BUF_VAZIO;
      saida_q      <= '0;
      canal_q      <= '0;
      skid_q       <= '0;
      skid_canal_q <= '0;
      ptr_q        <= '0;
    end else begin
      estado_q     <= estado_d;
      saida_q      <= saida_d;
      canal_q      <= canal_d;
      skid_q       <= skid_d;
      skid_canal_q <= skid_canal_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.saida        = saida_q;
  assign bus.saida_canal  = canal_q;
  assign bus.saida_valido = cheio;
  assign bus.estado_dbg   = estado_q;
  assign bus.ptr_dbg      = ptr_q;

  a_pronto_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.entr_pronto));

  a_saida_estavel: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.saida_valido && !bus.saida_pronto) |=>
      ($stable(bus.saida) && $stable(bus.saida_canal)));

endmodule

// File: tb/tb_muxn_reg_nrisc.sv
// Bench for muxn_reg_nrisc: fixed-select (4 and 3 channels) and round-robin
// builds driven by shared stimulus, each checked against an occupancy model.
module tb_muxn_reg_nrisc;
  import nrisc_pkg::*;

  localparam int W   = 8;
  localparam int IDX = idx_largura(4);
  localparam int EW  = IDX + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [4*W-1:0] entr_t;
  logic [3:0]     valido_t;
  logic [IDX-1:0] sinal_t;
  logic           pronto_t;

  muxn_reg_nrisc_if #(.LARGURA(W), .CANAIS(4), .IDX(IDX)) if_fix ();
  muxn_reg_nrisc_if #(.LARGURA(W), .CANAIS(3), .IDX(IDX)) if_c3 ();
  muxn_reg_nrisc_if #(.LARGURA(W), .CANAIS(4), .IDX(IDX)) if_rr ();

  assign if_fix.entr         = entr_t;
  assign if_fix.entr_valido  = valido_t;
  assign if_fix.sinal        = sinal_t;
  assign if_fix.saida_pronto = pronto_t;
  assign if_c3.entr          = entr_t[3*W-1:0];
  assign if_c3.entr_valido   = valido_t[2:0];
  assign if_c3.sinal         = sinal_t;
  assign if_c3.saida_pronto  = pronto_t;
  assign if_rr.entr          = entr_t;
  assign if_rr.entr_valido   = valido_t;
  assign if_rr.sinal         = sinal_t;
  assign if_rr.saida_pronto  = pronto_t;

  muxn_reg_nrisc #(.LARGURA(W), .CANAIS(4), .MODO(MODO_FIXO)) u_fix (
    .clk (clk), .rst_n (rst_n), .bus (if_fix));
  muxn_reg_nrisc #(.LARGURA(W), .CANAIS(3), .MODO(MODO_FIXO)) u_c3 (
    .clk (clk), .rst_n (rst_n), .bus (if_c3));
  muxn_reg_nrisc #(.LARGURA(W), .CANAIS(4), .MODO(MODO_RR)) u_rr (
    .clk (clk), .rst_n (rst_n), .bus (if_rr));

  logic [3:0]     o_pronto [3];
  logic           o_valid  [3];
  logic [W-1:0]   o_saida  [3];
  logic [IDX-1:0] o_canal  [3];
  logic [1:0]     o_estado [3];

  assign o_pronto[0] = if_fix.entr_pronto;
  assign o_pronto[1] = {1'b0, if_c3.entr_pronto};
  assign o_pronto[2] = if_rr.entr_pronto;
  assign o_valid[0]  = if_fix.saida_valido;
  assign o_valid[1]  = if_c3.saida_valido;
  assign o_valid[2]  = if_rr.saida_valido;
  assign o_saida[0]  = if_fix.saida;
  assign o_saida[1]  = if_c3.saida;
  assign o_saida[2]  = if_rr.saida;
  assign o_canal[0]  = if_fix.saida_canal;
  assign o_canal[1]  = if_c3.saida_canal;
  assign o_canal[2]  = if_rr.saida_canal;
  assign o_estado[0] = if_fix.estado_dbg;
  assign o_estado[1] = if_c3.estado_dbg;
  assign o_estado[2] = if_rr.estado_dbg;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  function automatic int q_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic void q_push(input int d, input logic [EW-1:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic logic [EW-1:0] q_pop(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void q_clear(input int d);
    case (d)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endfunction

  int m_cnt [3]     = '{0, 0, 0};
  int m_ptr [3]     = '{0, 0, 0};
  int canais_of [3] = '{4, 3, 4};
  bit rr_of [3]     = '{1'b0, 1'b0, 1'b1};

  // Model steps at the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int c, g, cand;
      bit have, acc, drn;
      logic [3:0] ep;
      logic [W-1:0] palavra;
      c    = canais_of[d];
      g    = 0;
      have = 1'b0;
      if (!rr_of[d]) begin
        have = 1'b1;
        g    = (int'(sinal_t) < c) ? int'(sinal_t) : 0;
      end else begin
        for (int k = 0; k < c; k++) begin
          cand = (m_ptr[d] + k) % c;
          if (!have && valido_t[cand[1:0]]) begin
            have = 1'b1;
            g    = cand;
          end
        end
      end
      ep = (have && m_cnt[d] < 2) ? 4'(1 << g) : 4'd0;
      check($sformatf("entr_pronto d%0d", d), o_pronto[d], ep);
      check($sformatf("saida_valido d%0d", d), o_valid[d], (m_cnt[d] > 0) ? 1 : 0);
      check($sformatf("estado d%0d", d), o_estado[d], m_cnt[d]);
      if (rr_of[d]) check($sformatf("ptr d%0d", d), if_rr.ptr_dbg, m_ptr[d]);

      if (!rst_n) begin
        m_cnt[d] = 0;
        m_ptr[d] = 0;
        q_clear(d);
      end else begin
        drn = (m_cnt[d] > 0) && pronto_t;
        acc = have && valido_t[g[1:0]] && (m_cnt[d] < 2);
        if (drn) begin
          if (q_size(d) == 0) check($sformatf("fila_underflow d%0d", d), 1, 0);
          else check($sformatf("saida_ordem d%0d", d), {o_canal[d], o_saida[d]}, q_pop(d));
        end
        if (acc) begin
          palavra = W'(entr_t >> (g * W));
          q_push(d, {IDX'(g), palavra});
          if (rr_of[d]) m_ptr[d] = (g + 1) % c;
        end
        m_cnt[d] = m_cnt[d] + int'(acc) - int'(drn);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] esp_stream [4] = '{8'd5, 8'd7, 8'd56, 8'd43};
  logic [7:0] bytes_rr   [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int         ord_rr     [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    entr_t   = {8'd43, 8'd56, 8'd7, 8'd5};
    valido_t = 4'hF;
    sinal_t  = '0;
    pronto_t = 1'b1;
    rst_n    = 1'b0;
    cyc(2);
    check("reset_valido fix", if_fix.saida_valido, 0);
    check("reset_saida fix", if_fix.saida, 0);
    check("reset_canal fix", if_fix.saida_canal, 0);
    check("reset_valido c3", if_c3.saida_valido, 0);
    check("reset_valido rr", if_rr.saida_valido, 0);
    check("reset_saida rr", if_rr.saida, 0);

    rst_n   = 1'b1;
    sinal_t = 2'd2;
    #1;
    check("pronto_sinal2", if_fix.entr_pronto, 4'b0100);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      sinal_t = IDX'(i);
      cyc(1);
      check("stream_saida", if_fix.saida, esp_stream[i]);
      check("stream_canal", if_fix.saida_canal, i);
      if (i == 3) begin
        check("c3_sinal3_canal", if_c3.saida_canal, 0);
        check("c3_sinal3_saida", if_c3.saida, 8'd5);
      end
    end

    // Backpressure: 3 and 9 buffered, 11 waits until the skid drains.
    valido_t = 4'b0000;
    cyc(2);
    sinal_t      = '0;
    entr_t[7:0]  = 8'd3;
    valido_t     = 4'b0001;
    cyc(1);
    check("bp_saida3", if_fix.saida, 8'd3);
    entr_t[7:0] = 8'd9;
    pronto_t    = 1'b0;
    cyc(1);
    check("bp_hold3", if_fix.saida, 8'd3);
    check("bp_pronto0", if_fix.entr_pronto, 4'b0000);
    check("bp_skid", if_fix.estado_dbg, BUF_DOIS);
    entr_t[7:0] = 8'd11;
    cyc(2);
    check("bp_hold3b", if_fix.saida, 8'd3);
    check("bp_pronto0b", if_fix.entr_pronto, 4'b0000);
    pronto_t = 1'b1;
    cyc(1);
    check("bp_saida9", if_fix.saida, 8'd9);
    check("bp_pronto_volta", if_fix.entr_pronto, 4'b0001);
    cyc(1);
    check("bp_saida11", if_fix.saida, 8'd11);
    valido_t = 4'b0000;
    cyc(2);

    // Round-robin fairness from a fresh pointer.
    rst_n = 1'b0;
    cyc(1);
    rst_n    = 1'b1;
    entr_t   = {bytes_rr[3], bytes_rr[2], bytes_rr[1], bytes_rr[0]};
    valido_t = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("rr_canal", if_rr.saida_canal, ord_rr[i]);
      check("rr_saida", if_rr.saida, bytes_rr[ord_rr[i]]);
      check("rr_ptr", if_rr.ptr_dbg, (ord_rr[i] + 1) % 4);
    end

    valido_t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("rr_idle_ptr", if_rr.ptr_dbg, 0);
      check("rr_idle_valido", if_rr.saida_valido, 0);
    end
    valido_t = 4'b0100;
    #1;
    check("rr_so_ch2_pronto", if_rr.entr_pronto, 4'b0100);
    cyc(1);
    check("rr_so_ch2_canal", if_rr.saida_canal, 2);
    check("rr_so_ch2_saida", if_rr.saida, bytes_rr[2]);

    // Reset with both buffer entries occupied.
    sinal_t     = '0;
    pronto_t    = 1'b0;
    entr_t[7:0] = 8'hA1;
    valido_t    = 4'b0001;
    cyc(1);
    entr_t[7:0] = 8'hA2;
    cyc(1);
    check("ms_cheio", if_fix.estado_dbg, BUF_DOIS);
    entr_t[7:0] = 8'hA3;
    rst_n       = 1'b0;
    cyc(1);
    check("ms_reset_valido", if_fix.saida_valido, 0);
    rst_n    = 1'b1;
    valido_t = 4'b0000;
    pronto_t = 1'b1;
    cyc(3);
    check("ms_sem_restos", if_fix.saida_valido, 0);
    entr_t[7:0] = 8'h55;
    valido_t    = 4'b0001;
    cyc(1);
    check("ms_novo", if_fix.saida, 8'h55);
    valido_t = 4'b0000;
    cyc(1);

    // Random traffic against the model.
    repeat (300) begin
      entr_t   = $urandom;
      valido_t = 4'($urandom_range(0, 15));
      sinal_t  = IDX'($urandom_range(0, 3));
      pronto_t = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    valido_t = 4'b0000;
    pronto_t = 1'b1;
    cyc(4);
    for (int d = 0; d < 3; d++) check($sformatf("fila_vazia d%0d", d), q_size(d), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
